// File: rtl/rm_mul_pkg.sv
// Shared types and helpers for the iterative radix-4 multiplier.
// Used by rm_mul_iter and mul2xn_digit.
package rm_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DIGIT_W = 2;

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rm_mul_iter_if.sv
// Operand/product valid-ready bundle for rm_mul_iter.
// master drives operands and takes products; slave is the multiplier.
interface rm_mul_iter_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/mul2xn_digit.sv
// 2-bit digit times WIDTH-bit operand, WIDTH+2 bit partial product.
// sgn_a: a is two's complement; sgn_d: digit is signed (-2..1).
module mul2xn_digit
  import rm_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic [WIDTH-1:0]   a,
  input  logic               sgn_a,
  input  logic               sgn_d,
  output logic [WIDTH+1:0]   pp
);

  logic [WIDTH+1:0] ax;
  logic [WIDTH+1:0] ax2;

  assign ax  = {{2{sgn_a & a[WIDTH-1]}}, a};
  assign ax2 = {ax[WIDTH:0], 1'b0};

  always_comb begin
    pp = '0;
    unique case (1'b1)
      digit == 2'd0:           pp = '0;
      digit == 2'd1:           pp = ax;
      digit == 2'd2 && !sgn_d: pp = ax2;
      digit == 2'd2 &&  sgn_d: pp = -ax2;
      digit == 2'd3 && !sgn_d: pp = ax + ax2;
      default:                 pp = -ax;
    endcase
  end

endmodule

// File: rtl/rm_mul_iter.sv
// Iterative WIDTH x WIDTH multiplier, one 2-bit digit of b per cycle.
// Define MUL_EARLY_TERM_EN to finish as soon as the remaining digits are 0.
module rm_mul_iter
  import rm_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  rm_mul_iter_if.slave bus
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = clog2(N);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sgn_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH+1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               rdy_q;
  logic               vld_q;
  logic [2*WIDTH-1:0] p_q;

  logic               top;
  logic               last;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+2:0]   sum;
  logic [WIDTH+1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic [2*WIDTH-1:0] prod;

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_p     = p_q;

  assign top = (cnt == CW'(N - 1));

  mul2xn_digit #(.WIDTH(WIDTH)) u_digit (
    .digit (b_q[DIGIT_W-1:0]),
    .a     (a_q),
    .sgn_a (sgn_q),
    .sgn_d (sgn_q & top),
    .pp    (pp)
  );

  // hi holds the upper product bits; two settled bits drop into lo per cycle
  assign sum  = {sgn_q & hi[WIDTH+1], hi}
              + {sgn_q & pp[WIDTH+1], pp};
  assign hi_n = {sgn_q & sum[WIDTH+2], sum[WIDTH+2:2]};
  assign lo_n = {sum[1:0], lo[WIDTH-1:2]};

`ifdef MUL_EARLY_TERM_EN
  logic signed [2*WIDTH+2:0] full;

  assign full = {sgn_q & hi_n[WIDTH+1], hi_n, lo_n};
  assign last = top
             || (b_q[WIDTH-1:DIGIT_W] == '0)
             || (a_q == '0);
  // skipped zero digits only shift, so align in one step
  assign prod = (2*WIDTH)'(full >>> (DIGIT_W * (N - 1 - int'(cnt))));
`else
  assign last = top;
  assign prod = {hi_n[WIDTH-1:0], lo_n};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            sgn_q <= bus.in_signed;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            rdy_q <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          hi  <= hi_n;
          lo  <= lo_n;
          b_q <= b_q >> DIGIT_W;
          cnt <= cnt + 1'b1;
          if (last) begin
            p_q   <= prod;
            vld_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rm_mul_iter.sv
// Directed and random checks of rm_mul_iter at WIDTH 8, 4 and 16.
// Expected latency follows MUL_EARLY_TERM_EN when it is defined.
module tb_rm_mul_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rm_mul_iter_if #(.WIDTH(8))  i8 ();
  rm_mul_iter_if #(.WIDTH(4))  i4 ();
  rm_mul_iter_if #(.WIDTH(16)) i16 ();

  rm_mul_iter #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (i8.slave)
  );

  rm_mul_iter #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (i4.slave)
  );

  rm_mul_iter #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (i16.slave)
  );

  function automatic int exp_lat8(input logic [7:0] a, b);
`ifdef MUL_EARLY_TERM_EN
    int l;
    l = 1;
    if (a == 8'd0) return 1;
    for (int k = 0; k < 4; k++)
      if (b[2*k +: 2] != 2'd0) l = k + 1;
    return l;
`else
    return 4;
`endif
  endfunction

  task automatic run8(input logic s, input logic [7:0] a, b,
                      output logic [15:0] p, output int lat);
    @(negedge clk);
    i8.in_valid  = 1'b1;
    i8.in_signed = s;
    i8.in_a      = a;
    i8.in_b      = b;
    @(posedge clk);
    #1;
    i8.in_valid  = 1'b0;
    i8.in_signed = ~s;
    i8.in_a      = ~a;
    i8.in_b      = ~b;
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = i8.out_p;
  endtask

  task automatic take8;
    @(negedge clk);
    i8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    i8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i8.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (i8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", i8.in_ready);
    end
    n_checks++;
    if (i8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b want 0", i8.out_valid);
    end
    n_checks++;
    if (i8.out_p !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out_p got %h want 0000", i8.out_p);
    end
    i8.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [32:0] vec [8];
    logic [15:0] p;
    logic [15:0] e;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    int          lat;
    vec[0] = {1'b1, 8'h80, 8'h80, 16'h4000};
    vec[1] = {1'b0, 8'hff, 8'hff, 16'hfe01};
    vec[2] = {1'b1, 8'hff, 8'hff, 16'h0001};
    vec[3] = {1'b1, 8'h7f, 8'h80, 16'hc080};
    vec[4] = {1'b0, 8'h00, 8'hb7, 16'h0000};
    vec[5] = {1'b1, 8'h5a, 8'h00, 16'h0000};
    vec[6] = {1'b1, 8'h0d, 8'hf9, 16'hffa5};
    vec[7] = {1'b0, 8'h80, 8'h80, 16'h4000};
    for (int i = 0; i < 8; i++) begin
      {s, a, b, e} = vec[i];
      run8(s, a, b, p, lat);
      n_checks++;
      if (p !== e) begin
        n_fail++;
        $display("FAIL vec%0d_p got %h want %h", i, p, e);
      end
      n_checks++;
      if (lat != exp_lat8(a, b)) begin
        n_fail++;
        $display("FAIL vec%0d_lat got %0d want %0d",
                 i, lat, exp_lat8(a, b));
      end
      take8();
    end
  endtask

  task automatic test_hold;
    logic [15:0] p;
    int          lat;
    run8(1'b1, 8'hff, 8'h05, p, lat);
    n_checks++;
    if (p !== 16'hfffb) begin
      n_fail++;
      $display("FAIL hold_p got %h want fffb", p);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i8.in_valid = 1'b1;
      i8.in_a     = 8'h11;
      i8.in_b     = 8'h22;
      n_checks++;
      if (i8.out_valid !== 1'b1 || i8.out_p !== 16'hfffb
          || i8.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_c%0d got v=%b p=%h r=%b want 1 fffb 0",
                 i, i8.out_valid, i8.out_p, i8.in_ready);
      end
    end
    i8.in_valid = 1'b0;
    take8();
    n_checks++;
    if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1
        || i8.out_p !== 16'hfffb) begin
      n_fail++;
      $display("FAIL hold_after got v=%b r=%b p=%h want 0 1 fffb",
               i8.out_valid, i8.in_ready, i8.out_p);
    end
  endtask

  task automatic test_abort;
    logic [15:0] p;
    int          lat;
    int          seen;
    @(negedge clk);
    i8.in_valid  = 1'b1;
    i8.in_signed = 1'b0;
    i8.in_a      = 8'd100;
    i8.in_b      = 8'd200;
    @(posedge clk);
    #1;
    i8.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0
        || i8.out_p !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_state got r=%b v=%b p=%h want 1 0 0000",
               i8.in_ready, i8.out_valid, i8.out_p);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (i8.out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_stale got %0d valid cycles want 0", seen);
    end
    run8(1'b0, 8'd3, 8'd7, p, lat);
    n_checks++;
    if (p !== 16'h0015) begin
      n_fail++;
      $display("FAIL abort_next got %h want 0015", p);
    end
    take8();
  endtask

  task automatic test_early_term;
    logic [15:0] p;
    int          lat;
    int          e;
`ifdef MUL_EARLY_TERM_EN
    e = 1;
`else
    e = 4;
`endif
    run8(1'b0, 8'd9, 8'd2, p, lat);
    n_checks++;
    if (p !== 16'h0012) begin
      n_fail++;
      $display("FAIL early_p got %h want 0012", p);
    end
    n_checks++;
    if (lat != e) begin
      n_fail++;
      $display("FAIL early_lat got %0d want %0d", lat, e);
    end
    take8();
  endtask

  task automatic test_back_to_back;
    int acc;
    int outs;
    int overlap;
    int badp;
    acc = 0;
    outs = 0;
    overlap = 0;
    badp = 0;
    @(negedge clk);
    i8.in_valid  = 1'b1;
    i8.in_signed = 1'b1;
    i8.in_a      = 8'hfd;
    i8.in_b      = 8'h9d;
    i8.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      if (i8.in_valid && i8.in_ready) acc++;
      if (i8.out_valid && i8.out_ready) begin
        outs++;
        if (i8.out_p !== 16'h0129) badp++;
      end
      if (i8.in_ready && i8.out_valid) overlap++;
      @(posedge clk);
    end
    #1;
    i8.in_valid  = 1'b0;
    i8.out_ready = 1'b0;
    n_checks++;
    if (acc != 3 || outs != 3) begin
      n_fail++;
      $display("FAIL b2b_count got acc=%0d out=%0d want 3 3", acc, outs);
    end
    n_checks++;
    if (overlap != 0 || badp != 0) begin
      n_fail++;
      $display("FAIL b2b_prod got overlap=%0d badp=%0d want 0 0",
               overlap, badp);
    end
  endtask

  task automatic test_random_w4;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] e;
    longint     x;
    int         lat;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      s = 1'($urandom);
      x = s ? longint'($signed(a)) * longint'($signed(b))
            : longint'(a) * longint'(b);
      e = x[7:0];
      @(negedge clk);
      i4.in_valid  = 1'b1;
      i4.in_signed = s;
      i4.in_a      = a;
      i4.in_b      = b;
      @(posedge clk);
      #1;
      i4.in_valid = 1'b0;
      lat = 0;
      while (!i4.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_checks++;
      if (!i4.out_valid || i4.out_p !== e) begin
        n_fail++;
        $display("FAIL w4_rand s=%b a=%h b=%h got %h want %h",
                 s, a, b, i4.out_p, e);
      end
      @(negedge clk);
      i4.out_ready = 1'b1;
      @(posedge clk);
      #1;
      i4.out_ready = 1'b0;
    end
  endtask

  task automatic test_random_w16;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] e;
    longint      x;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
      if (i == 1) begin a = 16'hffff; b = 16'hffff; s = 1'b0; end
      x = s ? longint'($signed(a)) * longint'($signed(b))
            : longint'(a) * longint'(b);
      e = x[31:0];
      @(negedge clk);
      i16.in_valid  = 1'b1;
      i16.in_signed = s;
      i16.in_a      = a;
      i16.in_b      = b;
      @(posedge clk);
      #1;
      i16.in_valid = 1'b0;
      lat = 0;
      while (!i16.out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_checks++;
      if (!i16.out_valid || i16.out_p !== e) begin
        n_fail++;
        $display("FAIL w16_rand s=%b a=%h b=%h got %h want %h",
                 s, a, b, i16.out_p, e);
      end
      @(negedge clk);
      i16.out_ready = 1'b1;
      @(posedge clk);
      #1;
      i16.out_ready = 1'b0;
    end
  endtask

  initial begin
    i8.in_valid   = 1'b0;
    i8.in_signed  = 1'b0;
    i8.in_a       = '0;
    i8.in_b       = '0;
    i8.out_ready  = 1'b0;
    i4.in_valid   = 1'b0;
    i4.in_signed  = 1'b0;
    i4.in_a       = '0;
    i4.in_b       = '0;
    i4.out_ready  = 1'b0;
    i16.in_valid  = 1'b0;
    i16.in_signed = 1'b0;
    i16.in_a      = '0;
    i16.in_b      = '0;
    i16.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_hold();
    test_abort();
    test_early_term();
    test_back_to_back();
    test_random_w4();
    test_random_w16();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
